// File: rtl/shifter_pkg.sv
// Op encoding and op-classification helpers shared by the pipelined barrel shifter.
package shifter_pkg;

  typedef enum logic [2:0] {
    SRL = 3'b000,
    SLL = 3'b001,
    SRA = 3'b010,
    ROR = 3'b011,
    ROL = 3'b100
  } shift_op_e;

  function automatic logic is_left(input logic [2:0] op);
    return (op == SLL) || (op == ROL);
  endfunction

  function automatic logic is_rotate(input logic [2:0] op);
    return (op == ROR) || (op == ROL);
  endfunction

  // Encodings above ROL pass the operand through untouched.
  function automatic logic is_reserved(input logic [2:0] op);
    return op > ROL;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One log2 step of the shifter: conditional right shift by 2^K, refilling the
// vacated top bits either with the bits shifted out (rotate) or with a fill bit.
module shift_stage #(
  parameter int N = 16,
  parameter int K = 0
) (
  input  logic [N-1:0] data_i,
  input  logic         en_i,
  input  logic         rotate_i,
  input  logic         fill_i,
  output logic [N-1:0] data_o
);

  localparam int S = 1 << K;

  logic [S-1:0] wrap;

  always_comb begin
    wrap   = rotate_i ? data_i[S-1:0] : {S{fill_i}};
    data_o = en_i ? {wrap, data_i[N-1:S]} : data_i;
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one registered shift_stage per amount bit, with a
// single global stall so the whole pipe freezes when the output is not taken.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int N   = 16,
  localparam int SHW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_data,
  input  logic [SHW-1:0] in_amount,
  input  logic [2:0]     in_op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data
);

  localparam int SBW = (SHW > 1) ? SHW - 1 : 1;

  logic           advance;
  logic [SHW-1:0] amt_in;
  logic [N-1:0]   in_rev;
  logic [N-1:0]   out_rev;

  logic [N-1:0]   stage_src [SHW];
  logic [N-1:0]   stage_out [SHW];
  logic [N-1:0]   data_d    [SHW];
  logic [2:0]     stage_op  [SHW];
  logic [SHW-1:0] stage_fill;
  logic [SHW-1:0] stage_en;
  logic [SHW-1:0] stage_vin;

  logic [N-1:0]   data_q [SHW];
  logic [SHW-1:0] valid_q;
  logic [2:0]     op_q   [SBW];
  logic [SBW-1:0] fill_q;

  assign advance   = ~valid_q[SHW-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign amt_in    = is_reserved(in_op) ? '0 : in_amount;

  // Left ops run through the right-shift core on bit-reversed data.
  for (genvar b = 0; b < N; b++) begin : g_rev
    assign in_rev[b]  = is_left(in_op) ? in_data[N-1-b] : in_data[b];
    assign out_rev[b] = stage_out[SHW-1][N-1-b];
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_src[k]  = in_rev;
      assign stage_op[k]   = in_op;
      assign stage_fill[k] = (in_op == SRA) & in_data[N-1];
      assign stage_en[k]   = amt_in[0];
      assign stage_vin[k]  = in_valid;
    end else begin : g_body
      // Amount bit k waits k cycles so it meets its data at stage k.
      logic [k-1:0] line_q;

      assign stage_src[k]  = data_q[k-1];
      assign stage_op[k]   = op_q[k-1];
      assign stage_fill[k] = fill_q[k-1];
      assign stage_en[k]   = line_q[k-1];
      assign stage_vin[k]  = valid_q[k-1];

      if (k == 1) begin : g_one
        always_ff @(posedge clk) begin
          if (reset) begin
            line_q <= '0;
          end else if (advance) begin
            line_q <= amt_in[k];
          end
        end
      end else begin : g_many
        always_ff @(posedge clk) begin
          if (reset) begin
            line_q <= '0;
          end else if (advance) begin
            line_q <= {line_q[k-2:0], amt_in[k]};
          end
        end
      end
    end

    shift_stage #(
      .N(N),
      .K(k)
    ) u_shift_stage (
      .data_i   (stage_src[k]),
      .en_i     (stage_en[k]),
      .rotate_i (is_rotate(stage_op[k])),
      .fill_i   (stage_fill[k]),
      .data_o   (stage_out[k])
    );
  end

  always_comb begin
    for (int k = 0; k < SHW; k++) begin
      data_d[k] = stage_out[k];
    end
    data_d[SHW-1] = is_left(stage_op[SHW-1]) ? out_rev : stage_out[SHW-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= '0;
      end
      for (int k = 0; k < SBW; k++) begin
        op_q[k] <= '0;
      end
      valid_q <= '0;
      fill_q  <= '0;
    end else if (advance) begin
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= data_d[k];
      end
      for (int k = 0; k < SBW; k++) begin
        op_q[k] <= stage_op[k];
      end
      valid_q <= stage_vin;
      fill_q  <= stage_fill[SBW-1:0];
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: directed vectors, stall and
// reset scenarios, then a long randomized run against an arithmetic model.
module tb_pipelined_barrel_shifter;

  localparam int N       = 16;
  localparam int LATENCY = 4;

  typedef struct {
    logic [N-1:0] data;
    int           acceptCycle;
    bit           checkLat;
  } sbEntry_t;

  logic         clock    = 1'b0;
  logic         reset    = 1'b1;
  logic         inValid  = 1'b0;
  logic         inReady;
  logic [N-1:0] inData   = '0;
  logic [3:0]   inAmount = '0;
  logic [2:0]   inOp     = '0;
  logic         outValid;
  logic         outReady = 1'b1;
  logic [N-1:0] outData;

  int           assertCount = 0;
  int           failCount   = 0;
  int           cycleCnt    = 0;
  int           readyMode   = 0;
  bit           latCheck    = 0;
  bit           dirUse      = 0;
  logic [N-1:0] dirExp      = '0;
  sbEntry_t     sbQueue[$];

  pipelined_barrel_shifter #(.N(N)) dut (
    .clk       (clock),
    .reset     (reset),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_data   (inData),
    .in_amount (inAmount),
    .in_op     (inOp),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt++;

  // Golden model: plain shift arithmetic on a double-width word.
  function automatic logic [N-1:0] refModel(input logic [N-1:0] d, input int amt, input logic [2:0] op);
    logic [2*N-1:0]      w;
    logic signed [N-1:0] s;
    logic [N-1:0]        r;
    w = {{N{1'b0}}, d};
    s = d;
    case (op)
      3'd0:    r = d >> amt;
      3'd1:    r = N'(w << amt);
      3'd2:    r = s >>> amt;
      3'd3:    r = N'((w >> amt) | (w << (N - amt)));
      3'd4:    r = N'((w << amt) | (w >> (N - amt)));
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  always @(posedge clock) begin
    #2;
    case (readyMode)
      0:       outReady = 1'b1;
      1:       outReady = 1'b0;
      default: outReady = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: records accepts and checks every output take against the queue.
  always @(negedge clock) begin
    sbEntry_t e;
    if (!reset) begin
      if (inValid && inReady) begin
        e.data        = dirUse ? dirExp : refModel(inData, int'(inAmount), inOp);
        e.acceptCycle = cycleCnt;
        e.checkLat    = latCheck;
        sbQueue.push_back(e);
      end
      if (outValid && outReady) begin
        if (sbQueue.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected_output: got 0x%0h, required no output (cycle %0d)", outData, cycleCnt);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("result", 32'(outData), 32'(e.data));
          if (e.checkLat) checkOutput("latency", cycleCnt - e.acceptCycle, LATENCY);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [N-1:0] d, input logic [3:0] a, input logic [2:0] op,
                               input bit useExp, input logic [N-1:0] expv);
    int waitCycles = 0;
    @(posedge clock);
    #1;
    inData   = d;
    inAmount = a;
    inOp     = op;
    dirUse   = useExp;
    dirExp   = expv;
    inValid  = 1'b1;
    @(negedge clock);
    while (!inReady && waitCycles < 200) begin
      @(negedge clock);
      waitCycles++;
    end
    if (!inReady) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
    inValid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbQueue.size() != 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    checkOutput("drain_queue_empty", sbQueue.size(), 0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_in_ready", inReady, 1);
    checkOutput("reset_out_data", 32'(outData), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Directed vectors with exact latency.
    latCheck = 1;
    applyStimulus(16'h0001, 4'd4,  3'd1, 1, 16'h0010);
    applyStimulus(16'h8001, 4'd1,  3'd4, 1, 16'h0003);
    applyStimulus(16'h8000, 4'd15, 3'd2, 1, 16'hFFFF);
    applyStimulus(16'h8000, 4'd15, 3'd0, 1, 16'h0001);
    applyStimulus(16'h0001, 4'd1,  3'd3, 1, 16'h8000);
    applyStimulus(16'hA5C3, 4'd9,  3'd6, 1, 16'hA5C3);
    applyStimulus(16'h9F31, 4'd0,  3'd2, 1, 16'h9F31);
    idle();
    waitDrain();

    // Back-to-back: fixed latency on consecutive accepts implies consecutive results.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(N'($urandom), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 4)), 0, '0);
    end
    idle();
    waitDrain();
    latCheck = 0;

    // Stall with a full pipe, a fifth item held at the input throughout.
    @(posedge clock);
    #1;
    readyMode = 1;
    applyStimulus(16'h1234, 4'd8, 3'd3, 1, 16'h3412);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(N'($urandom), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 0, '0);
    end
    fork
      applyStimulus(16'hC0DE, 4'd3, 3'd1, 0, '0);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clock);
          checkOutput("stall_out_data", 32'(outData), 32'h3412);
          checkOutput("stall_out_valid", outValid, 1);
          checkOutput("stall_in_ready", inReady, 0);
        end
        @(posedge clock);
        #1;
        readyMode = 0;
      end
    join
    idle();
    waitDrain();

    // Reset with three items in flight.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(N'($urandom), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 4)), 0, '0);
    end
    @(posedge clock);
    #1;
    reset   = 1'b1;
    inValid = 1'b0;
    sbQueue.delete();
    @(posedge clock);
    @(negedge clock);
    checkOutput("midreset_out_valid", outValid, 0);
    checkOutput("midreset_in_ready", inReady, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post_reset_out_valid", outValid, 0);
    checkOutput("post_reset_in_ready", inReady, 1);
    repeat (10) @(negedge clock);

    // Randomized run with random back-pressure and input gaps.
    readyMode = 2;
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(N'($urandom), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 0, '0);
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();
    @(posedge clock);
    #1;
    readyMode = 0;
    waitDrain();
    repeat (5) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
